// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma front-end sequencer.
package enigma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CRYPT = 2'd2
    } ctrl_state_e;

    localparam int TBL_DEPTH = 64;
    localparam int NUM_TBL   = 3;

    // Index of the final table entry across all three tables.
    localparam logic [7:0] LOAD_LAST = 8'd191;

    localparam logic [1:0] TBL_ROTA = 2'd0;
    localparam logic [1:0] TBL_ROTB = 2'd1;
    localparam logic [1:0] TBL_REFL = 2'd2;

endpackage

// File: rtl/enigma_ctrl_if.sv
// Symbol stream, datapath feedback and strobe bundle around enigma_ctrl.
interface enigma_ctrl_if;
    logic       in_valid;
    logic [5:0] in_data;
    logic       crypt_mode;
    logic [5:0] rotorA_forward_out;
    logic [5:0] rotorB_backward_out;
    logic [5:0] rotorA_backward_out;
    logic       load;
    logic [1:0] table_idx;
    logic       encrypt;
    logic [5:0] code_in;
    logic [1:0] rotorA_shift_amount;
    logic       out_valid;
    logic [5:0] out_code;

    modport master (
        output in_valid, in_data, crypt_mode,
        output rotorA_forward_out, rotorB_backward_out, rotorA_backward_out,
        input  load, table_idx, encrypt, code_in, rotorA_shift_amount,
        input  out_valid, out_code
    );

    modport slave (
        input  in_valid, in_data, crypt_mode,
        input  rotorA_forward_out, rotorB_backward_out, rotorA_backward_out,
        output load, table_idx, encrypt, code_in, rotorA_shift_amount,
        output out_valid, out_code
    );
endinterface

// File: rtl/enigma_ctrl.sv
// Enigma front-end sequencer: table-load strobes, encrypt strobes, rotorA shift.
// ENIGMA_CTRL_SHIFT_EN enables data-dependent rotorA rotation; otherwise it is held at 0.
module enigma_ctrl
    import enigma_pkg::*;
(
    input  logic         clk,
    input  logic         srst_n,
    enigma_ctrl_if.slave bus
);

    ctrl_state_e state_r;
    logic [7:0]  load_cnt_r;
    logic        loaded_r;
    logic        mode_q_r;
    logic        in_run_r;

    logic        load_s;
    logic        encrypt_s;
    logic        first_enc_s;
    logic        mode_eff_s;
    logic [1:0]  shift_s;

    // Strobe decode; the IDLE cycle already consumes the session's first symbol
    always_comb begin
        load_s    = 1'b0;
        encrypt_s = 1'b0;
        if (bus.in_valid) begin
            case (state_r)
                IDLE: begin
                    load_s    = ~loaded_r;
                    encrypt_s = loaded_r;
                end
                LOAD:    load_s    = 1'b1;
                CRYPT:   encrypt_s = 1'b1;
                default: begin
                    load_s    = 1'b0;
                    encrypt_s = 1'b0;
                end
            endcase
        end else begin
            load_s    = 1'b0;
            encrypt_s = 1'b0;
        end
    end

    // A run starts on any encrypt not preceded by an encrypt, so the mode is sampled live there
    assign first_enc_s = encrypt_s & ~in_run_r;
    assign mode_eff_s  = first_enc_s ? bus.crypt_mode : mode_q_r;

`ifdef ENIGMA_CTRL_SHIFT_EN
    logic unused_s;

    // Decrypt uses rotorB's backward output, which equals rotorA's image of the plaintext
    always_comb begin
        shift_s = 2'd0;
        if (encrypt_s) begin
            if (mode_eff_s) begin
                shift_s = bus.rotorA_forward_out[1:0];
            end else begin
                shift_s = bus.rotorB_backward_out[1:0];
            end
        end else begin
            shift_s = 2'd0;
        end
    end

    assign unused_s = ^{bus.rotorA_forward_out[5:2], bus.rotorB_backward_out[5:2]};
`else
    logic unused_s;

    assign shift_s  = 2'd0;
    assign unused_s = ^{bus.rotorA_forward_out, bus.rotorB_backward_out, mode_eff_s};
`endif

    assign bus.load                = load_s;
    assign bus.encrypt             = encrypt_s;
    assign bus.table_idx           = load_cnt_r[7:6];
    assign bus.code_in             = (load_s | encrypt_s) ? bus.in_data : 6'd0;
    assign bus.rotorA_shift_amount = shift_s;

    // Session FSM, table-load counter, run mode latch and registered datapath result
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state_r       <= IDLE;
            load_cnt_r    <= 8'd0;
            loaded_r      <= 1'b0;
            mode_q_r      <= 1'b1;
            in_run_r      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_code  <= 6'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_r <= loaded_r ? CRYPT : LOAD;
                    end
                end
                LOAD: begin
                    if (load_s && (load_cnt_r == LOAD_LAST)) begin
                        state_r <= CRYPT;
                    end
                end
                CRYPT: begin
                    if (!bus.in_valid) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase

            if (load_s) begin
                if (load_cnt_r == LOAD_LAST) begin
                    load_cnt_r <= 8'd0;
                    loaded_r   <= 1'b1;
                end else begin
                    load_cnt_r <= load_cnt_r + 8'd1;
                end
            end

            if (first_enc_s) begin
                mode_q_r <= bus.crypt_mode;
            end

            in_run_r      <= encrypt_s;
            bus.out_valid <= encrypt_s;
            bus.out_code  <= encrypt_s ? bus.rotorA_backward_out : 6'd0;
        end
    end

endmodule

// File: tb/tb_enigma_ctrl.sv
// Randomized bench for enigma_ctrl against a symbol-count reference model.
module tb_enigma_ctrl;

    logic clk = 1'b0;
    logic srst_n;

    always #5 clk = ~clk;

    enigma_ctrl_if bus();

    enigma_ctrl dut (
        .clk    (clk),
        .srst_n (srst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: symbols loaded so far, whether last cycle carried a character, run mode
    int         m_loaded;
    bit         m_prev_enc;
    bit         m_run_mode;
    bit         m_ov;
    logic [5:0] m_oc;
    bit         m_known;
    int         load_pulses;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst_lo, input bit v, input logic [5:0] d, input bit m,
                        input logic [5:0] fwd, input logic [5:0] bwdb, input logic [5:0] bwda);
        bit         e_load;
        bit         e_enc;
        bit         mode;
        logic [1:0] e_idx;
        logic [1:0] e_shift;
        logic [5:0] e_code;
        @(negedge clk);
        srst_n                  = ~rst_lo;
        bus.in_valid            = v;
        bus.in_data             = d;
        bus.crypt_mode          = m;
        bus.rotorA_forward_out  = fwd;
        bus.rotorB_backward_out = bwdb;
        bus.rotorA_backward_out = bwda;
        #1;
        e_load  = v && (m_loaded < 192);
        e_enc   = v && (m_loaded >= 192);
        e_idx   = (m_loaded < 192) ? 2'(m_loaded / 64) : 2'd0;
        e_code  = (e_load || e_enc) ? d : 6'd0;
        mode    = m_prev_enc ? m_run_mode : m;
        e_shift = 2'd0;
`ifdef ENIGMA_CTRL_SHIFT_EN
        if (e_enc) e_shift = mode ? 2'(fwd % 64'd4) : 2'(bwdb % 64'd4);
`endif
        if (m_known) begin
            check_val("load",      32'(bus.load),                32'(e_load));
            check_val("encrypt",   32'(bus.encrypt),             32'(e_enc));
            check_val("table_idx", 32'(bus.table_idx),           32'(e_idx));
            check_val("code_in",   32'(bus.code_in),             32'(e_code));
            check_val("shift",     32'(bus.rotorA_shift_amount), 32'(e_shift));
            check_val("out_valid", 32'(bus.out_valid),           32'(m_ov));
            check_val("out_code",  32'(bus.out_code),            32'(m_oc));
        end
        if (bus.load === 1'b1) load_pulses++;
        if (rst_lo) begin
            m_loaded   = 0;
            m_prev_enc = 1'b0;
            m_run_mode = 1'b1;
            m_ov       = 1'b0;
            m_oc       = 6'd0;
            m_known    = 1'b1;
        end else if (m_known) begin
            if (e_load) m_loaded++;
            if (e_enc && !m_prev_enc) m_run_mode = m;
            m_prev_enc = e_enc;
            m_ov       = e_enc;
            m_oc       = e_enc ? bwda : 6'd0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'd0, 1'($urandom), 6'($urandom), 6'($urandom), 6'($urandom));
    endtask

    task automatic rnd_cycle(input int pct);
        step(1'b0, ($urandom_range(99) < pct), 6'($urandom), 1'($urandom),
             6'($urandom), 6'($urandom), 6'($urandom));
    endtask

    initial begin
        srst_n                  = 1'b0;
        bus.in_valid            = 1'b0;
        bus.in_data             = 6'd0;
        bus.crypt_mode          = 1'b0;
        bus.rotorA_forward_out  = 6'd0;
        bus.rotorB_backward_out = 6'd0;
        bus.rotorA_backward_out = 6'd0;
        m_known                 = 1'b0;
        m_loaded                = 0;
        load_pulses             = 0;

        step(1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 6'd0, 6'd0);
        step(1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 6'd0, 6'd0);
        idle(2);

        // Full table load with a three-cycle gap before symbol 70
        load_pulses = 0;
        for (int i = 0; i < 192; i++) begin
            if (i == 70) idle(3);
            step(1'b0, 1'b1, 6'(i % 64), 1'($urandom), 6'($urandom), 6'($urandom), 6'($urandom));
        end
        check_val("load_pulses", 32'(load_pulses), 32'd192);

        // Character right after the last table entry, encrypt mode
        step(1'b0, 1'b1, 6'd5, 1'b1, 6'h2B, 6'($urandom), 6'h11);
        for (int i = 0; i < 20; i++) rnd_cycle(100);
        idle(2);

        // Decrypt session; crypt_mode flips mid-run without effect
        load_pulses = 0;
        step(1'b0, 1'b1, 6'd9, 1'b0, 6'($urandom), 6'h2B, 6'h22);
        for (int i = 0; i < 12; i++) rnd_cycle(100);
        idle(1);
        check_val("no_reload", 32'(load_pulses), 32'd0);

        for (int i = 0; i < 200; i++) rnd_cycle(75);

        // Reset while a result is pending
        step(1'b0, 1'b1, 6'd7, 1'b1, 6'd3, 6'd1, 6'h2A);
        step(1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 6'd0, 6'd0);
        idle(2);

        // Reset in the middle of a table load, then reload from scratch
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 6'($urandom), 1'b0, 6'd0, 6'd0, 6'd0);
        step(1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 6'd0, 6'd0);
        idle(1);
        for (int i = 0; i < 2000 && m_loaded < 192; i++) rnd_cycle(80);
        check_val("reload_done", 32'(m_loaded), 32'd192);

        for (int i = 0; i < 300; i++) rnd_cycle(70);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
